// File: rtl/gate_selftest_seq.sv
// Self-test sequencer for a two-input gate stage: applies {a,b}=0..3, waits a
// programmable settle time, checks all six gate outputs and reports the results.
module gate_selftest_seq #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_g,
  input  logic       or_g,
  input  logic       nand_g,
  input  logic       nor_g,
  input  logic       xor_g,
  input  logic       xnor_g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [5:0] fail_mask,
  output logic [1:0] first_fail
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [5:0] mask_q, mask_d;
  logic [1:0] first_q, first_d;
  logic [5:0] exp_g, mis;

  // Expected values come from the registered stimulus, never from the inputs.
  always_comb begin
    exp_g = {a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q), a_q ^ b_q, ~(a_q ^ b_q)};
    mis   = exp_g ^ {and_g, or_g, nand_g, nor_g, xor_g, xnor_g};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          {a_d, b_d} = 2'b00;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          mask_d  = 6'd0;
          first_d = 2'd0;
        end
      end
      APPLY: begin
        cnt_d   = SETTLE_LD;
        state_d = (SETTLE_LD == 4'd0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        mask_d = mask_q | mis;
        if (mis != 6'd0) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) first_d = idx_q;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          // Loaded on entry so pass is visible together with the done pulse.
          pass_d  = (err_d == 3'd0);
        end else begin
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
          state_d    = APPLY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 6'd0;
      first_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      first_q <= first_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_mask  = mask_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Directed bench: a table of full runs against a faultable gate model, plus
// hand-written reset and settle-time corner sequences.
module tb_gate_selftest_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int fault = 0;  // 0 good, 1 xor stuck at 0, 2 and wired to nand
  int checks = 0;
  int errors = 0;

  // DUT with SETTLE_CYCLES=2 (faultable model) and SETTLE_CYCLES=0 (good model)
  logic start2 = 1'b0, a2, b2, and2, or2, nand2, nor2, xor2, xnor2;
  logic busy2, done2, pass2;
  logic [2:0] err2; logic [5:0] mask2; logic [1:0] first2;
  logic start0 = 1'b0, a0, b0, and0, or0, nand0, nor0, xor0, xnor0;
  logic busy0, done0, pass0;
  logic [2:0] err0; logic [5:0] mask0; logic [1:0] first0;

  function automatic logic [5:0] gm(input logic x, input logic y, input int f);
    logic [5:0] g;
    g = {x & y, x | y, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
    if (f == 1) g[1] = 1'b0;
    if (f == 2) g[5] = ~(x & y);
    return g;
  endfunction

  assign {and2, or2, nand2, nor2, xor2, xnor2} = gm(a2, b2, fault);
  assign {and0, or0, nand0, nor0, xor0, xnor0} = gm(a0, b0, 0);

  gate_selftest_seq #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .and_g(and2), .or_g(or2), .nand_g(nand2), .nor_g(nor2), .xor_g(xor2), .xnor_g(xnor2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_mask(mask2),
    .first_fail(first2));

  gate_selftest_seq #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .and_g(and0), .or_g(or0), .nand_g(nand0), .nor_g(nor0), .xor_g(xor0), .xnor_g(xnor0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0),
    .first_fail(first0));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    bit    s0;      // run on the SETTLE_CYCLES=0 instance
    bit    extra;   // re-assert start at cycles 5 and 10
    int    flt;
    bit    e_pass;
    int    e_err;
    int    e_mask;
    int    e_first;
  } vec_t;

  // Start sampled at edge 0; observe cycles 1..30 at the falling edge.
  task automatic run(input vec_t v);
    int s, dexp, dcyc, dcnt;
    bit ab_ok, busy_ok, d, bs, aa, bb;
    s = v.s0 ? 0 : 2;
    dexp = 4 * (s + 2) + 1;
    dcyc = -1; dcnt = 0; ab_ok = 1'b1; busy_ok = 1'b1;
    fault = v.flt;
    @(negedge clk);
    if (v.s0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      d  = v.s0 ? done0 : done2;
      bs = v.s0 ? busy0 : busy2;
      aa = v.s0 ? a0 : a2;
      bb = v.s0 ? b0 : b2;
      if (d) begin dcnt++; if (dcyc < 0) dcyc = cyc; end
      if (bs != (cyc <= dexp)) busy_ok = 1'b0;
      if (cyc <= 4 * (s + 2) && ((cyc - 1) % (s + 2)) == 0 &&
          int'({aa, bb}) != (cyc - 1) / (s + 2)) ab_ok = 1'b0;
      start0 = 1'b0;
      start2 = !v.s0 && v.extra && (cyc == 5 || cyc == 10);
    end
    chk({v.name, " done_cycle"}, dcyc, dexp);
    chk({v.name, " done_count"}, dcnt, 1);
    chk({v.name, " ab_sequence"}, int'(ab_ok), 1);
    chk({v.name, " busy_window"}, int'(busy_ok), 1);
    chk({v.name, " pass"},       int'(v.s0 ? pass0 : pass2), int'(v.e_pass));
    chk({v.name, " err_count"},  int'(v.s0 ? err0 : err2), v.e_err);
    chk({v.name, " fail_mask"},  int'(v.s0 ? mask0 : mask2), v.e_mask);
    chk({v.name, " first_fail"}, int'(v.s0 ? first0 : first2), v.e_first);
  endtask

  vec_t tbl[5];
  int dn;

  initial begin
    tbl[0] = '{"good",        1'b0, 1'b0, 0, 1'b1, 0, 6'b000000, 0};
    tbl[1] = '{"xor_stuck0",  1'b0, 1'b0, 1, 1'b0, 2, 6'b000010, 1};
    tbl[2] = '{"and_is_nand", 1'b0, 1'b0, 2, 1'b0, 4, 6'b100000, 0};
    tbl[3] = '{"start_busy",  1'b0, 1'b1, 0, 1'b1, 0, 6'b000000, 0};
    tbl[4] = '{"settle0",     1'b1, 1'b0, 0, 1'b1, 0, 6'b000000, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", int'(busy2), 0);
    chk("rst done", int'(done2), 0);
    chk("rst pass", int'(pass2), 0);
    chk("rst ab",   int'({a2, b2}), 0);
    chk("rst err",  int'(err2), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run(tbl[i]);

    // Mid-run reset: asserted for edge 8, everything back to reset values in cycle 9.
    fault = 0;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (cyc == 8) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("midrst ab",    int'({a2, b2}), 0);
    chk("midrst busy",  int'(busy2), 0);
    chk("midrst done",  int'(done2), 0);
    chk("midrst pass",  int'(pass2), 0);
    chk("midrst err",   int'(err2), 0);
    chk("midrst mask",  int'(mask2), 0);
    chk("midrst first", int'(first2), 0);
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (done2) dn++; end
    chk("midrst no_done", dn, 0);
    run(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
